// File: rtl/cyq_194_sequencer.sv
// Running-light sequencer for a 74HC194-style 4-bit universal shift register.
// Each round is a parallel load, STEPS right shifts, then STEPS left shifts, one mode per prescaler tick.
module cyq_194_sequencer #(
  parameter int DIV   = 4,
  parameter int STEPS = 4
) (
  input  logic       clk,
  input  logic       MR,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [3:0] pattern,
  input  logic       fill,
  output logic [1:0] S,
  output logic       Dsr,
  output logic       Dsl,
  output logic [3:0] D,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHR, ST_SHL} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pre;
  logic [3:0] r_step;
  logic [3:0] r_pat;
  logic       r_fill;
  logic [1:0] r_s;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_tick;
  logic       w_last;
  logic [1:0] w_s;
  logic       w_done;
  logic       w_busy;

  assign w_accept = (r_state == ST_IDLE) && start && !stop;
  assign w_tick   = (r_state != ST_IDLE) && (r_pre == 8'(DIV - 1));
  assign w_last   = ((r_step + 4'd1) == 4'(STEPS));

  // State register
  always_ff @(posedge clk or posedge MR) begin
    if (MR) r_state <= ST_IDLE;
    else    r_state <= w_next;
  end

  // Next-state logic; stop overrides any tick in a busy state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LOAD;
      ST_LOAD: begin
        if (stop)        w_next = ST_IDLE;
        else if (w_tick) w_next = ST_SHR;
      end
      ST_SHR: begin
        if (stop)                  w_next = ST_IDLE;
        else if (w_tick && w_last) w_next = ST_SHL;
      end
      ST_SHL: begin
        if (stop)                  w_next = ST_IDLE;
        else if (w_tick && w_last) w_next = loop ? ST_LOAD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode, registered below so the register sees a mode for exactly one cycle
  always_comb begin
    w_s    = 2'b00;
    w_done = 1'b0;
    w_busy = (w_next != ST_IDLE);
    if (w_tick && !stop) begin
      case (r_state)
        ST_LOAD: w_s = 2'b11;
        ST_SHR:  w_s = 2'b01;
        ST_SHL: begin
          w_s    = 2'b10;
          w_done = w_last && !loop;
        end
        default: w_s = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      r_s    <= 2'b00;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pat  <= 4'b0000;
      r_fill <= 1'b0;
      r_pre  <= 8'd0;
      r_step <= 4'd0;
    end else begin
      r_s    <= w_s;
      r_busy <= w_busy;
      r_done <= w_done;
      if (w_accept) begin
        r_pat  <= pattern;
        r_fill <= fill;
      end
      // Prescaler restarts on every accepted start and only runs while a run is active
      if (w_accept || stop)           r_pre <= 8'd0;
      else if (r_state == ST_IDLE)    r_pre <= r_pre;
      else if (w_tick)                r_pre <= 8'd0;
      else                            r_pre <= r_pre + 8'd1;
      if (w_accept || stop)           r_step <= 4'd0;
      else if (!w_tick)               r_step <= r_step;
      else if (r_state == ST_LOAD)    r_step <= 4'd0;
      else if (w_last)                r_step <= 4'd0;
      else                            r_step <= r_step + 4'd1;
    end
  end

  assign S    = r_s;
  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_pat;
  assign Dsr  = r_fill;
  assign Dsl  = r_fill;

endmodule

// File: tb/tb_cyq_194_sequencer.sv
// Randomized bench for cyq_194_sequencer: two parameterisations checked against an
// arithmetic schedule model (emission k of a run lands DIV*(k+1) edges after start).
module tb_cyq_194_sequencer;

  localparam int DIV0 = 4;
  localparam int ST0  = 3;
  localparam int DIV1 = 1;
  localparam int ST1  = 1;

  logic       clk = 1'b0;
  logic       MR;
  logic       start, stop, loop, fill;
  logic [3:0] pattern;

  logic [1:0] s_o   [2];
  logic       dsr_o [2];
  logic       dsl_o [2];
  logic [3:0] d_o   [2];
  logic       busy_o[2];
  logic       done_o[2];

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_busy[2];
  int         m_n   [2];
  logic [3:0] m_pat [2];
  logic       m_fill[2];
  logic [1:0] e_s   [2];
  logic       e_done[2];

  always #5 clk = ~clk;

  cyq_194_sequencer #(.DIV(DIV0), .STEPS(ST0)) u_dut0 (
    .clk(clk), .MR(MR), .start(start), .stop(stop), .loop(loop),
    .pattern(pattern), .fill(fill), .S(s_o[0]), .Dsr(dsr_o[0]), .Dsl(dsl_o[0]),
    .D(d_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  cyq_194_sequencer #(.DIV(DIV1), .STEPS(ST1)) u_dut1 (
    .clk(clk), .MR(MR), .start(start), .stop(stop), .loop(loop),
    .pattern(pattern), .fill(fill), .S(s_o[1]), .Dsr(dsr_o[1]), .Dsl(dsl_o[1]),
    .D(d_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int steps_of(input int i);
    return (i == 0) ? ST0 : ST1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_n[i] = 0; m_pat[i] = 4'b0000; m_fill[i] = 1'b0;
      e_s[i] = 2'b00;   e_done[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference: positions in the round follow from elapsed cycles
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int k, pos, st;
      st = steps_of(i);
      e_s[i] = 2'b00;
      e_done[i] = 1'b0;
      if (!m_busy[i]) begin
        if (start && !stop) begin
          m_busy[i] = 1'b1; m_n[i] = 0; m_pat[i] = pattern; m_fill[i] = fill;
        end
      end else if (stop) begin
        m_busy[i] = 1'b0;
      end else begin
        m_n[i]++;
        if (m_n[i] % div_of(i) == 0) begin
          k   = m_n[i] / div_of(i) - 1;
          pos = k % (2 * st + 1);
          e_s[i] = (pos == 0) ? 2'b11 : ((pos <= st) ? 2'b01 : 2'b10);
          if (pos == 2 * st && !loop) begin
            m_busy[i] = 1'b0;
            e_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("S[%0d]", i),    int'(s_o[i]),    int'(e_s[i]));
      check_eq($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_busy[i]));
      check_eq($sformatf("done[%0d]", i), int'(done_o[i]), int'(e_done[i]));
      check_eq($sformatf("D[%0d]", i),    int'(d_o[i]),    int'(m_pat[i]));
      check_eq($sformatf("Dsr[%0d]", i),  int'(dsr_o[i]),  int'(m_fill[i]));
      check_eq($sformatf("Dsl[%0d]", i),  int'(dsl_o[i]),  int'(m_fill[i]));
    end
  endtask

  // Advance one edge, check just after it; optionally pulse MR mid-cycle
  task automatic cyc(input bit mr_pulse);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (mr_pulse) begin
      #2 MR = 1'b1;
      #1;
      model_reset();
      check_all();
      #2 MR = 1'b0;
    end
  endtask

  initial begin
    MR = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; fill = 1'b0; pattern = 4'b0000;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    MR = 1'b0;

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    cyc(1'b0);
    start = 1'b0; stop = 1'b0;
    cyc(1'b0);

    // single round, fill 0
    pattern = 4'b1000; fill = 1'b0; loop = 1'b0; start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (35) cyc(1'b0);

    // single round, fill 1, inputs wiggled mid-run and start re-pulsed while busy
    pattern = 4'b0000; fill = 1'b1; start = 1'b1;
    cyc(1'b0);
    start = 1'b0; pattern = 4'b1111; fill = 1'b0;
    repeat (10) cyc(1'b0);
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (25) cyc(1'b0);

    // looping rounds, then stop
    loop = 1'b1; pattern = 4'b0101; start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (62) cyc(1'b0);
    stop = 1'b1;
    cyc(1'b0);
    stop = 1'b0;
    repeat (3) cyc(1'b0);

    // asynchronous MR during SHL of the DIV=4 instance, then a fresh run
    loop = 1'b0; start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (22) cyc(1'b0);
    cyc(1'b1);
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (32) cyc(1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) loop = 1'($urandom);
      pattern = 4'($urandom);
      fill    = 1'($urandom);
      cyc($urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
